// File: rtl/fetch_decode_reg_ctrl.sv
// IF/ID pipeline register: stall hold, flush-to-bubble, valid tagging and sticky halt, all on the falling clock edge.
// Optional saturating stall/flush counters are built only when FD_PERF_CNT_EN is defined.
module fetch_decode_reg_ctrl #(
  parameter int unsigned               NB_DATA   = 32,
  parameter int unsigned               NB_PC     = 7,
  parameter logic [NB_DATA-1:0]        NOP_WORD  = '0,
  parameter logic [NB_DATA-1:0]        HALT_WORD = '1,
  parameter int unsigned               NB_CNT    = 16
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               en_pipeline,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic [NB_PC-1:0]   pc_i,
  input  logic [NB_DATA-1:0] instruction_i,
  output logic [NB_PC-1:0]   pc_o,
  output logic [NB_DATA-1:0] instruction_o,
  output logic               valid_o,
`ifdef FD_PERF_CNT_EN
  output logic               halt_o,
  output logic [NB_CNT-1:0]  stall_cnt_o,
  output logic [NB_CNT-1:0]  flush_cnt_o
`else
  output logic               halt_o
`endif
);

  // Parameter sanity checked at elaboration so both builds reference NB_CNT.
  if (NB_CNT == 0 || NB_PC == 0 || NB_DATA == 0) begin : g_bad_width
    $error("fetch_decode_reg_ctrl: widths must be nonzero");
  end

  logic [NB_PC-1:0]   r_pc;
  logic [NB_DATA-1:0] r_instr;
  logic               r_valid;
  logic               r_halt;
  logic               w_hold;
  logic               w_is_halt;

  // Halted register ignores everything except reset, exactly like a disabled pipeline.
  assign w_hold    = !en_pipeline || r_halt;
  assign w_is_halt = (instruction_i == HALT_WORD);

  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      r_pc    <= '0;
      r_instr <= NOP_WORD;
      r_valid <= 1'b0;
      r_halt  <= 1'b0;
    end else if (!w_hold) begin
      if (flush_i) begin
        r_pc    <= pc_i;
        r_instr <= NOP_WORD;
        r_valid <= 1'b0;
      end else if (!stall_i) begin
        r_pc    <= pc_i;
        r_instr <= instruction_i;
        r_valid <= 1'b1;
        r_halt  <= w_is_halt;
      end
    end
  end

  assign pc_o          = r_pc;
  assign instruction_o = r_instr;
  assign valid_o       = r_valid;
  assign halt_o        = r_halt;

`ifdef FD_PERF_CNT_EN
  logic [NB_CNT-1:0] r_stall_cnt;
  logic [NB_CNT-1:0] r_flush_cnt;

  // Flush outranks stall, so a cycle with both only bumps the flush counter.
  always_ff @(negedge clock_i) begin
    if (reset_i) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!w_hold) begin
      if (flush_i) begin
        if (r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + NB_CNT'(1);
      end else if (stall_i) begin
        if (r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
      end
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
`endif

endmodule

// File: tb/tb_fetch_decode_reg_ctrl.sv
// Directed bench for fetch_decode_reg_ctrl; counter checks are active when FD_PERF_CNT_EN is defined.
module tb_fetch_decode_reg_ctrl;

  logic        clk = 1'b0;
  logic        reset_i = 1'b1, en_pipeline = 1'b1, stall_i = 1'b0, flush_i = 1'b0;
  logic [6:0]  pc_i = '0;
  logic [31:0] instruction_i = '0;
  logic [6:0]  pc_o;
  logic [31:0] instruction_o;
  logic        valid_o, halt_o;
  logic [40:0] obs;
  int unsigned n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

`ifdef FD_PERF_CNT_EN
  logic [15:0] stall_cnt_o, flush_cnt_o;
  logic [31:0] cnt;
  logic        s_reset = 1'b1, s_stall = 1'b0;
  logic [6:0]  s_pc;
  logic [31:0] s_instr;
  logic        s_valid, s_halt;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  assign cnt = {stall_cnt_o, flush_cnt_o};

  fetch_decode_reg_ctrl #(.NB_DATA(32), .NB_PC(7), .NB_CNT(16)) dut (
    .clock_i(clk), .reset_i(reset_i), .en_pipeline(en_pipeline), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .instruction_i(instruction_i), .pc_o(pc_o),
    .instruction_o(instruction_o), .valid_o(valid_o), .halt_o(halt_o),
    .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o));

  fetch_decode_reg_ctrl #(.NB_DATA(32), .NB_PC(7), .NB_CNT(2)) u_sat (
    .clock_i(clk), .reset_i(s_reset), .en_pipeline(1'b1), .stall_i(s_stall),
    .flush_i(1'b0), .pc_i(7'd1), .instruction_i(32'h1), .pc_o(s_pc),
    .instruction_o(s_instr), .valid_o(s_valid), .halt_o(s_halt),
    .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt));
`else
  fetch_decode_reg_ctrl #(.NB_DATA(32), .NB_PC(7)) dut (
    .clock_i(clk), .reset_i(reset_i), .en_pipeline(en_pipeline), .stall_i(stall_i),
    .flush_i(flush_i), .pc_i(pc_i), .instruction_i(instruction_i), .pc_o(pc_o),
    .instruction_o(instruction_o), .valid_o(valid_o), .halt_o(halt_o));
`endif

  assign obs = {pc_o, instruction_o, valid_o, halt_o};

  // Apply inputs, let one falling edge pass, then sample 1 time unit later.
  task automatic step(input logic rst, input logic en, input logic stl, input logic fl,
                      input logic [6:0] pc, input logic [31:0] ins);
    reset_i = rst; en_pipeline = en; stall_i = stl; flush_i = fl;
    pc_i = pc; instruction_i = ins;
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 32'h0000_0001);
    step(1'b1, 1'b0, 1'b1, 1'b1, 7'h55, 32'hFFFF_FFFF);
    n_vec++;
    if (obs !== {7'd0, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL reset: got %h want %h", obs, {7'd0, 32'h0, 1'b0, 1'b0});
    end
`ifdef FD_PERF_CNT_EN
    n_vec++;
    if (cnt !== 32'h0) begin n_err++; $display("FAIL reset_cnt: got %h want %h", cnt, 32'h0); end
`endif
  endtask

  task automatic test_load();
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd4, 32'h2008_0005);
    n_vec++;
    if (obs !== {7'd4, 32'h2008_0005, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL load: got %h want %h", obs, {7'd4, 32'h2008_0005, 1'b1, 1'b0});
    end
  endtask

  task automatic test_stall();
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd8, 32'h0109_5020);
    n_vec++;
    if (obs !== {7'd8, 32'h0109_5020, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL stall_load: got %h want %h", obs, {7'd8, 32'h0109_5020, 1'b1, 1'b0});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, 7'(9 + i), 32'hA000_0000 + 32'(i));
      n_vec++;
      if (obs !== {7'd8, 32'h0109_5020, 1'b1, 1'b0}) begin
        n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, obs, {7'd8, 32'h0109_5020, 1'b1, 1'b0});
      end
    end
`ifdef FD_PERF_CNT_EN
    n_vec++;
    if (cnt !== {16'd3, 16'd0}) begin n_err++; $display("FAIL stall_cnt: got %h want %h", cnt, {16'd3, 16'd0}); end
`endif
  endtask

  task automatic test_flush_over_stall();
    step(1'b0, 1'b1, 1'b1, 1'b1, 7'd12, 32'h1234_5678);
    n_vec++;
    if (obs !== {7'd12, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL flush: got %h want %h", obs, {7'd12, 32'h0, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd13, 32'h5555_5555);
    n_vec++;
    if (obs !== {7'd12, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL bubble_hold: got %h want %h", obs, {7'd12, 32'h0, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b0, 1'b1, 7'd20, 32'hFFFF_FFFF);
    n_vec++;
    if (obs !== {7'd20, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL halt_flushed: got %h want %h", obs, {7'd20, 32'h0, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b1, 1'b0, 7'd21, 32'hFFFF_FFFF);
    n_vec++;
    if (obs !== {7'd20, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL halt_stalled: got %h want %h", obs, {7'd20, 32'h0, 1'b0, 1'b0});
    end
`ifdef FD_PERF_CNT_EN
    n_vec++;
    if (cnt !== {16'd5, 16'd2}) begin n_err++; $display("FAIL flush_cnt: got %h want %h", cnt, {16'd5, 16'd2}); end
`endif
  endtask

  task automatic test_enable();
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd5, 32'h0000_AAAA);
    step(1'b0, 1'b0, 1'b0, 1'b1, 7'd6, 32'h0000_BBBB);
    n_vec++;
    if (obs !== {7'd5, 32'h0000_AAAA, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL en_flush: got %h want %h", obs, {7'd5, 32'h0000_AAAA, 1'b1, 1'b0});
    end
    step(1'b0, 1'b0, 1'b1, 1'b0, 7'd7, 32'hFFFF_FFFF);
    n_vec++;
    if (obs !== {7'd5, 32'h0000_AAAA, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL en_stall: got %h want %h", obs, {7'd5, 32'h0000_AAAA, 1'b1, 1'b0});
    end
`ifdef FD_PERF_CNT_EN
    n_vec++;
    if (cnt !== {16'd5, 16'd2}) begin n_err++; $display("FAIL en_cnt: got %h want %h", cnt, {16'd5, 16'd2}); end
`endif
  endtask

  task automatic test_halt();
    logic [3:0] ctl [5];
    ctl = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0000};
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd30, 32'hFFFF_FFFF);
    n_vec++;
    if (obs !== {7'd30, 32'hFFFF_FFFF, 1'b1, 1'b1}) begin
      n_err++; $display("FAIL halt_capture: got %h want %h", obs, {7'd30, 32'hFFFF_FFFF, 1'b1, 1'b1});
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, ctl[i][1], ctl[i][0], 7'(40 + i), 32'h0000_1000 + 32'(i));
      n_vec++;
      if (obs !== {7'd30, 32'hFFFF_FFFF, 1'b1, 1'b1}) begin
        n_err++; $display("FAIL halt_frozen%0d: got %h want %h", i, obs, {7'd30, 32'hFFFF_FFFF, 1'b1, 1'b1});
      end
    end
`ifdef FD_PERF_CNT_EN
    n_vec++;
    if (cnt !== {16'd5, 16'd2}) begin n_err++; $display("FAIL halt_cnt: got %h want %h", cnt, {16'd5, 16'd2}); end
`endif
    step(1'b1, 1'b1, 1'b0, 1'b0, 7'd50, 32'h0);
    n_vec++;
    if (obs !== {7'd0, 32'h0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL halt_reset: got %h want %h", obs, {7'd0, 32'h0, 1'b0, 1'b0});
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 7'd51, 32'h0000_0077);
    n_vec++;
    if (obs !== {7'd51, 32'h0000_0077, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL post_halt_load: got %h want %h", obs, {7'd51, 32'h0000_0077, 1'b1, 1'b0});
    end
  endtask

`ifdef FD_PERF_CNT_EN
  task automatic test_saturation();
    s_reset = 1'b1; s_stall = 1'b0;
    @(negedge clk); #1;
    s_reset = 1'b0; s_stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk); #1;
      n_vec++;
      if (s_stall_cnt !== ((i > 3) ? 2'd3 : 2'(i))) begin
        n_err++; $display("FAIL sat_stall%0d: got %0d want %0d", i, s_stall_cnt, (i > 3) ? 2'd3 : 2'(i));
      end
    end
    n_vec++;
    if ({s_pc, s_valid, s_flush_cnt} !== {7'd0, 1'b0, 2'd0}) begin
      n_err++; $display("FAIL sat_other: got %h want %h", {s_pc, s_valid, s_flush_cnt}, {7'd0, 1'b0, 2'd0});
    end
    s_stall = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_load();
    test_stall();
    test_flush_over_stall();
    test_enable();
    test_halt();
`ifdef FD_PERF_CNT_EN
    test_saturation();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
